exe_stage: RTL
==============

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 freeze  in  1  hold every internal register (input, output, status) this cycle.
REQ-004 flush  in  1  load a bubble into the input register this cycle.
REQ-005 pc_in  in  32  PC of the incoming instruction.
REQ-006 wb_en_in, mem_read_en_in, mem_write_en_in, s_in, b_in, is_immediate_in  in  1 each  control bits from decode.
REQ-007 exe_command_in  in  4  ALU op: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR; any other code gives result 0 with flags unchanged.
REQ-008 val_rn_in, val_rm_in  in  32 each  register operands.
REQ-009 imm_8_in  in  8 / rotate_imm_in  in  4 / signed_imm_in  in  24 / dest_in  in  4  immediate fields and destination.
REQ-010 status_reg_out  out  32  NZCV in [31:28], bits [27:0] constant 0; fed back to the decode condition check.
REQ-011 branch_taken  out  1  / branch_addr  out  32  registered branch request and target.
REQ-012 wb_en, mem_read_en, mem_write_en  out  1 each  / alu_result, st_val  out  32  / dest  out  4  registered EX/MEM outputs.

Function
REQ-013 Two register ranks: rank A (input) captures all *_in ports; rank B (output) captures results computed from rank A; total latency 2 edges from input to output.
REQ-014 Rank A update priority: rst > freeze (hold) > flush (all control bits and exe_command zero, data fields don't-care) > capture.
REQ-015 Rank B and status register update priority: rst > freeze (hold) > update.
REQ-016 val2 when is_immediate=1: zero-extended imm_8 rotated right by 2*rotate_imm (0..30 bits).
REQ-017 val2 when is_immediate=0 and (mem_read_en or mem_write_en)=1: zero-extended {rotate_imm, imm_8} (12-bit offset).
REQ-018 val2 otherwise: val_rm shifted by shift_imm={rotate_imm, imm_8[7]} using type imm_8[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR; shift_imm 0 returns val_rm unchanged.
REQ-019 Arithmetic in 33 bits: ADD rn+val2; ADC rn+val2+C; SUB rn+~val2+1; SBC rn+~val2+C; C = bit 32 (not-borrow for SUB/SBC).
REQ-020 V for add-type = (rn[31]==val2[31]) and (res[31]!=rn[31]); for subtract-type = (rn[31]!=val2[31]) and (res[31]!=rn[31]).
REQ-021 Logic/move ops (MOV, MVN, AND, ORR, EOR) update N and Z only; C and V retained.
REQ-022 Memory ops (mem_read_en or mem_write_en) force ALU to ADD regardless of exe_command; st_val = val_rm.
REQ-023 Status register loads new NZCV on the rank-B edge only when rank A holds s=1; otherwise holds.
REQ-024 Carry input for ADC/SBC is the status C value before the current instruction's update.
REQ-025 branch_taken registered = rank A b; branch_addr = pc + (sign-extended signed_imm << 2), 32-bit wrap-around.
REQ-026 A bubble (all controls 0) produces wb_en=mem_read_en=mem_write_en=branch_taken=0 and no flag change.
REQ-027 Unused combinations (b=1 with wb_en=1) pass through unchanged; no checking.

Reset
REQ-028 rst=1 at an edge clears rank A, rank B and status register to 0: all outputs 0, status_reg_out=0x00000000.
REQ-029 rst asserted mid-operation discards any in-flight instruction; first valid output appears 2 edges after rst deasserts with valid input.
REQ-030 rst overrides freeze and flush in the same cycle.

Verification
REQ-031 ADD imm: rn=5, imm_8=0x03, rotate_imm=0, is_immediate=1, s=1 -> 2 edges later alu_result=8, status [31:28]=0000.
REQ-032 SUB overflow: rn=0x80000000, val_rm=1, shift_imm 0, s=1 -> alu_result=0x7FFFFFFF, NZCV=0011.
REQ-033 Rotate: imm_8=0xFF, rotate_imm=4 -> val2=0xFF000000; MOV gives alu_result=0xFF000000, N=1 when s=1.
REQ-034 Branch: pc_in=0x100, signed_imm=0xFFFFFE, b=1 -> branch_taken=1, branch_addr=0x000000F8.
REQ-035 Freeze+flush same cycle: rank A holds previous instruction, outputs unchanged; flush alone -> next outputs all control 0, status held.
REQ-036 ADC chain: ADD 0xFFFFFFFF+1 with s=1 (C=1) then ADC 0+0 -> second alu_result=1.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: input register rank, barrel shifter / ALU / branch target, output register rank, NZCV status.
// Latency: 2 rising edges from *_in ports to registered EX/MEM outputs.
// No handshake: freeze stalls every register, flush inserts a bubble into the input rank.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic        wb_en_in,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  input  logic        s_in,
  input  logic        b_in,
  input  logic        is_immediate_in,
  input  logic [3:0]  exe_command_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [7:0]  imm_8_in,
  input  logic [3:0]  rotate_imm_in,
  input  logic [23:0] signed_imm_in,
  input  logic [3:0]  dest_in,
  output logic [31:0] status_reg_out,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic        wb_en,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] alu_result,
  output logic [31:0] st_val,
  output logic [3:0]  dest
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  // rank A (input register)
  logic [31:0] a_pc;
  logic        a_wb, a_mr, a_mw, a_s, a_b, a_imm;
  logic [3:0]  a_cmd;
  logic [31:0] a_rn, a_rm;
  logic [7:0]  a_imm8;
  logic [3:0]  a_rot;
  logic [23:0] a_simm;
  logic [3:0]  a_dest;

  // NZCV flags
  logic [3:0]  nzcv;

  // combinational results from rank A
  logic [31:0] val2;
  logic [31:0] imm32;
  logic [4:0]  rot_amt;
  logic [4:0]  shift_imm;
  logic [3:0]  alu_cmd;
  logic [32:0] sum;
  logic [31:0] res;
  logic        n_f, z_f, c_f, v_f;
  logic [31:0] br_target;

  // Capture decode outputs; flush zeroes everything so a bubble carries no controls.
  always_ff @(posedge clk) begin
    if (rst || (flush && !freeze)) begin
      a_pc   <= '0;
      a_wb   <= 1'b0;
      a_mr   <= 1'b0;
      a_mw   <= 1'b0;
      a_s    <= 1'b0;
      a_b    <= 1'b0;
      a_imm  <= 1'b0;
      a_cmd  <= '0;
      a_rn   <= '0;
      a_rm   <= '0;
      a_imm8 <= '0;
      a_rot  <= '0;
      a_simm <= '0;
      a_dest <= '0;
    end else if (!freeze) begin
      a_pc   <= pc_in;
      a_wb   <= wb_en_in;
      a_mr   <= mem_read_en_in;
      a_mw   <= mem_write_en_in;
      a_s    <= s_in;
      a_b    <= b_in;
      a_imm  <= is_immediate_in;
      a_cmd  <= exe_command_in;
      a_rn   <= val_rn_in;
      a_rm   <= val_rm_in;
      a_imm8 <= imm_8_in;
      a_rot  <= rotate_imm_in;
      a_simm <= signed_imm_in;
      a_dest <= dest_in;
    end
  end

  // Second operand: rotated immediate, 12-bit memory offset, or shifted register.
  always_comb begin
    imm32     = {24'd0, a_imm8};
    rot_amt   = {a_rot, 1'b0};
    shift_imm = {a_rot, a_imm8[7]};
    val2      = a_rm;
    if (a_imm) begin
      // a shift by 32 yields 0, so rotate-by-zero falls out naturally
      val2 = (imm32 >> rot_amt) | (imm32 << (6'd32 - {1'b0, rot_amt}));
    end else if (a_mr || a_mw) begin
      val2 = {20'd0, a_rot, a_imm8};
    end else if (shift_imm != 5'd0) begin
      case (a_imm8[6:5])
        2'b00:   val2 = a_rm << shift_imm;
        2'b01:   val2 = a_rm >> shift_imm;
        2'b10:   val2 = $unsigned($signed(a_rm) >>> shift_imm);
        default: val2 = (a_rm >> shift_imm) | (a_rm << (6'd32 - {1'b0, shift_imm}));
      endcase
    end
  end

  // ALU and flag generation; flags default to the current status so logic ops keep C/V.
  always_comb begin
    alu_cmd = (a_mr || a_mw) ? CMD_ADD : a_cmd;
    sum     = '0;
    res     = '0;
    n_f     = nzcv[3];
    z_f     = nzcv[2];
    c_f     = nzcv[1];
    v_f     = nzcv[0];
    case (alu_cmd)
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: begin
        case (alu_cmd)
          CMD_MOV: res = val2;
          CMD_MVN: res = ~val2;
          CMD_AND: res = a_rn & val2;
          CMD_ORR: res = a_rn | val2;
          default: res = a_rn ^ val2;
        endcase
        n_f = res[31];
        z_f = (res == 32'd0);
      end
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, a_rn} + {1'b0, val2} + {32'd0, (alu_cmd == CMD_ADC) & nzcv[1]};
        res = sum[31:0];
        n_f = res[31];
        z_f = (res == 32'd0);
        c_f = sum[32];
        v_f = (a_rn[31] == val2[31]) && (res[31] != a_rn[31]);
      end
      CMD_SUB, CMD_SBC: begin
        sum = {1'b0, a_rn} + {1'b0, ~val2}
            + {32'd0, (alu_cmd == CMD_SUB) ? 1'b1 : nzcv[1]};
        res = sum[31:0];
        n_f = res[31];
        z_f = (res == 32'd0);
        c_f = sum[32];
        v_f = (a_rn[31] != val2[31]) && (res[31] != a_rn[31]);
      end
      default: res = '0;
    endcase
  end

  // Branch target: word offset, sign-extended, wraps at 32 bits.
  always_comb begin
    br_target = a_pc + {{6{a_simm[23]}}, a_simm, 2'b00};
  end

  // Rank B (output register).
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en        <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      alu_result   <= '0;
      st_val       <= '0;
      dest         <= '0;
      branch_taken <= 1'b0;
      branch_addr  <= '0;
    end else if (!freeze) begin
      wb_en        <= a_wb;
      mem_read_en  <= a_mr;
      mem_write_en <= a_mw;
      alu_result   <= res;
      st_val       <= a_rm;
      dest         <= a_dest;
      branch_taken <= a_b;
      branch_addr  <= br_target;
    end
  end

  // Status register loads only for flag-setting instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv <= '0;
    end else if (!freeze && a_s) begin
      nzcv <= {n_f, z_f, c_f, v_f};
    end
  end

  assign status_reg_out = {nzcv, 28'd0};

endmodule
